// File: rtl/dark_fetch.sv
// Instruction-fetch front end: drives a 1-cycle-latency ROM and queues the returned words,
// tagged with their PC, in a first-word-fall-through buffer for the decode stage.
module dark_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        XCLK,
  input  logic        XRES,
  output logic        rom_enable,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0] fetch_pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rptr_q, wptr_q;
  logic        fault_q;

  logic [31:0] mem_data [FIFO_DEPTH];
  logic [31:0] mem_pc   [FIFO_DEPTH];

  logic        pop, push, has_space;
  logic [CW:0] occ;

  assign inst_valid = !XRES && (count_q != '0);
  assign inst_data  = inst_valid ? mem_data[rptr_q] : NOP;
  assign inst_pc    = inst_valid ? mem_pc[rptr_q]   : 32'h0;
  assign fault      = fault_q;
  assign rom_addr   = fetch_pc_q;

  assign pop  = inst_valid && inst_ready && !redirect;
  assign push = inflight_q && !redirect;

  // Slots already claimed (queued + in flight) minus the one leaving this cycle.
  always_comb begin
    occ       = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    has_space = occ < DEPTH_W;
  end

  assign rom_enable = !XRES && !redirect && !fault_q && has_space;

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      rptr_q        <= '0;
      wptr_q        <= '0;
      fault_q       <= 1'b0;
    end else if (redirect) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        fault_q <= 1'b1;
      end
    end else begin
      inflight_q <= rom_enable;
      if (rom_enable) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + 32'd4;
      end
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Queue storage needs no reset; count gates visibility.
  always_ff @(posedge XCLK) begin
    if (!XRES && push) begin
      mem_data[wptr_q] <= rom_data;
      mem_pc[wptr_q]   <= inflight_pc_q;
    end
  end

  always_ff @(posedge XCLK) begin
    if (!XRES) begin
      assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
    end
  end

endmodule

// File: doc/dark_fetch.md
Name: dark_fetch

Overview:
- Instruction-fetch front end that sits directly upstream of the 1-cycle-latency instruction ROM. It drives the ROM's enable/address and captures the returned words.
- Captured words go into a small first-word-fall-through prefetch queue, each tagged with its PC, and are handed to the decode stage over a valid/ready handshake.
- Handles sequential PC advance, branch/jump redirect with flush, and misaligned-target fault.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- XCLK  in  1  clock; all state updates on rising edge.
- XRES  in  1  reset; synchronous, active-high.
- rom_enable  out  1  ROM read request this cycle (combinational from state and redirect).
- rom_addr  out  32  byte address of request; equals fetch_pc.
- rom_data  in  32  ROM word; valid in the cycle after a cycle with rom_enable=1.
- redirect  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  target byte address, sampled when redirect=1.
- inst_valid  out  1  queue head holds an instruction.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  byte address of the head instruction.
- inst_ready  in  1  decode accepts head this cycle.
- fault  out  1  sticky misaligned-redirect flag.

Behaviour:
State:
- fetch_pc (32b), inflight (1b), inflight_pc (32b), queue storage, count (0..FIFO_DEPTH), fault (1b).

Reset (XRES=1 at an edge):
- fetch_pc=RESET_PC, inflight=0, count=0, fault=0.
- While XRES=1: rom_enable=0, inst_valid=0, inst_data=32'h0000_0013, inst_pc=0.

Pop:
- Occurs when inst_valid & inst_ready & !redirect.
- inst_data/inst_pc reflect the head combinationally; when empty they show 32'h0000_0013 and 0.

Issue condition:
- rom_enable = !XRES & !redirect & !fault & (count + inflight - pop < FIFO_DEPTH).
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Without issue: inflight<=0.

Push:
- When inflight=1 & !redirect, {rom_data, inflight_pc} is written at the tail at the end of that cycle.
- Space is guaranteed by the issue condition; overflow is impossible and is asserted against in simulation.

Simultaneous push and pop:
- Count unchanged; legal at count=FIFO_DEPTH.
- Sustained throughput is 1 instr/cycle with inst_ready held high.

Latency:
- First cycle after reset release issues RESET_PC.
- inst_valid=1 with inst_pc=RESET_PC two cycles later.

Redirect (cycle c, redirect=1):
- Queue flushed (count<=0); any pop that cycle is ignored.
- rom_data arriving in c is discarded; rom_enable=0 in c; inflight<=0.
- If redirect_pc[1:0]==0: fetch_pc<=redirect_pc. rom_addr=redirect_pc with rom_enable=1 in c+1; inst_valid=1 with inst_pc=redirect_pc in c+3.
- If redirect_pc[1:0]!=0: fault<=1 and fetch_pc<=redirect_pc & ~3.
  - While fault=1: no issues, inst_valid stays 0.
  - Only XRES clears fault.
- Redirect during fault: flush only; fault unchanged.

Stall:
- With inst_ready=0, the queue fills to FIFO_DEPTH, then rom_enable drops.
- Head outputs stay stable while inst_valid=1 & !inst_ready (no change without pop or redirect).

Out-of-range PCs:
- Not checked here; the ROM returns NOP and it is queued normally.

Reset mid-operation:
- Any in-flight ROM response and all queue contents are dropped.
- Fetch restarts at RESET_PC per the latency rule.

Test Plan:
- Reset release, inst_ready=1, ROM word i = 32'h1000_0000+i -> inst_valid first at cycle 2; then one instruction per cycle: inst_pc 0,4,8,… and inst_data 32'h1000_0000,32'h1000_0001,… with no gaps.
- inst_ready=0 for 10 cycles after reset -> exactly 4 pushes, rom_enable=0 once count+inflight=4. Release ready -> PCs 0..12 drain in order, then 16 follows with no bubble.
- Redirect to 32'h0000_0100 while queue holds 3 entries and a request is in flight -> inst_valid=0 in c+1 and c+2; c+3 head inst_pc=32'h100; no stale PC ever appears.
- Redirect to 32'h0000_0102 -> fault=1 from the next cycle, rom_enable stays 0, inst_valid stays 0. XRES pulse -> fault=0, fetch resumes at RESET_PC.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- XRES asserted for 1 cycle while queue is full and inst_ready=0 -> all outputs at reset values in the reset cycle; first post-reset head is inst_pc=RESET_PC.
